rename_map_table: RTL and testbench

Next-generation register alias table for the rename stage. It renames up to DECODE_WIDTH instructions per cycle and keeps both a speculative and an architectural map. It adds a circular checkpoint ring so a mispredicted branch recovers in one cycle, and a flush recovers from the internal architectural map. It sits between decode/free-list and dispatch/ROB, and is updated by commit.

---
 rtl/rat_pkg.sv | 39 +++
 rtl/rat_ckpt_ring.sv | 102 ++++++++++
 rtl/rename_map_table.sv | 151 +++++++++++++++
 tb/tb_rename_map_table.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// ---------------------------------------------------------------------------
// rat_pkg
// Shared types and constants for the register alias table (rename map).
//   preg_t    : physical register index
//   areg_t    : logical (architectural) register index
//   ckpt_id_t : checkpoint slot index
//   ckpt_cnt_t: live checkpoint count (one extra bit so "full" is representable)
//   rat_t     : a complete logical -> physical map
//   RAT_RESET_IDENTITY : map with logical r -> physical r
// ---------------------------------------------------------------------------
package rat_pkg;

  localparam int DECODE_WIDTH = 4;
  localparam int PHY_REG_NUM  = 64;
  localparam int ARCH_REG_NUM = 32;
  localparam int CKPT_NUM     = 8;

  localparam int PREG_W = $clog2(PHY_REG_NUM);
  localparam int AREG_W = 5;
  localparam int CKPT_W = $clog2(CKPT_NUM);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;
  typedef logic [CKPT_W:0]   ckpt_cnt_t;

  typedef preg_t [ARCH_REG_NUM-1:0] rat_t;

  function automatic rat_t identity_map();
    rat_t m;
    for (int r = 0; r < ARCH_REG_NUM; r++) begin
      m[r] = preg_t'(r);
    end
    return m;
  endfunction

  localparam rat_t RAT_RESET_IDENTITY = identity_map();

endpackage

// File: rtl/rat_ckpt_ring.sv
// ---------------------------------------------------------------------------
// rat_ckpt_ring
// Circular buffer of speculative-map snapshots used for one-cycle branch
// recovery. Slots are allocated at tail and retired at head.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   alloc, alloc_map     : store alloc_map at tail and advance tail
//   alloc_id             : slot that the next allocation will use (tail)
//   free                 : retire the oldest snapshot (head)
//   redirect, redirect_id: roll back to snapshot redirect_id, dropping
//                          everything younger than it
//   redirect_map         : snapshot stored at redirect_id
//   flush                : discard every snapshot
//   full, empty          : occupancy flags
// ---------------------------------------------------------------------------
module rat_ckpt_ring
  import rat_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     alloc,
  input  rat_t     alloc_map,
  output ckpt_id_t alloc_id,
  input  logic     free,
  input  logic     redirect,
  input  ckpt_id_t redirect_id,
  output rat_t     redirect_map,
  input  logic     flush,
  output logic     full,
  output logic     empty
);

  rat_t      slots [CKPT_NUM];
  ckpt_id_t  head, tail, head_next, tail_next;
  ckpt_cnt_t count, count_next;
  logic      redirect_live;

  assign alloc_id     = tail;
  assign redirect_map = slots[redirect_id];
  assign full         = (count == ckpt_cnt_t'(CKPT_NUM));
  assign empty        = (count == '0);

  // A retire in the same cycle is applied before the redirect, so the
  // recomputed count is measured from the already-advanced head. The count
  // is the distance to the redirect slot plus one, which keeps a redirect
  // to the youngest slot of a completely full ring at CKPT_NUM instead of 0.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (free) begin
        head_next  = head + 1'b1;
        count_next = count - 1'b1;
      end
      if (redirect) begin
        tail_next  = redirect_id + 1'b1;
        count_next = ckpt_cnt_t'(ckpt_id_t'(redirect_id - head_next)) + 1'b1;
      end else if (alloc) begin
        tail_next  = tail + 1'b1;
        count_next = count_next + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CKPT_NUM; i++) begin
        slots[i] <= RAT_RESET_IDENTITY;
      end
    end else if (alloc && !redirect && !flush) begin
      slots[tail] <= alloc_map;
    end
  end

  // A slot is live when its distance from head is below the live count.
  assign redirect_live =
    (ckpt_cnt_t'(ckpt_id_t'(redirect_id - head)) < count);

  a_redirect_live : assert property (@(posedge clk) disable iff (!rst_n)
    (redirect && !flush) |-> redirect_live);

  a_free_not_empty : assert property (@(posedge clk) disable iff (!rst_n)
    free |-> !empty);

endmodule

// File: rtl/rename_map_table.sv
// ---------------------------------------------------------------------------
// rename_map_table
// Register alias table for the rename stage. Renames up to DECODE_WIDTH
// instructions per cycle against a speculative map, keeps an architectural
// map updated by commit, snapshots the speculative map for branches, and
// recovers on redirect (from a snapshot) or flush (from the arch map).
// Optional feature macro: RAT_ZERO_REG_EN -- logical r0 is hardwired to
// physical 0 and never written in any map.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rn_valid_i            : per-lane instruction valid
//   rn_ready_o            : rename group accepted this cycle
//   rn_src0_i, rn_src1_i  : logical sources
//   rn_dest_i             : logical destination
//   rn_dest_valid_i       : lane writes a destination
//   rn_preg_i             : physical register from the free list
//   rn_ckpt_req_i         : lane is a branch needing a checkpoint
//   rn_psrc0_o, rn_psrc1_o: renamed sources
//   rn_ppdst_o            : previous mapping of the destination
//   rn_ckpt_id_o          : checkpoint id allocated this cycle
//   cm_valid_i, cm_dest_i, cm_preg_i : committing lanes
//   cm_ckpt_free_i        : oldest checkpoint retired
//   redirect_i, redirect_ckpt_i      : branch mispredict recovery
//   flush_i               : full flush back to the architectural map
//   ckpt_full_o, ckpt_empty_o        : checkpoint ring occupancy
// ---------------------------------------------------------------------------
module rename_map_table
  import rat_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DECODE_WIDTH-1:0]      rn_valid_i,
  output logic                         rn_ready_o,
  input  areg_t [DECODE_WIDTH-1:0]     rn_src0_i,
  input  areg_t [DECODE_WIDTH-1:0]     rn_src1_i,
  input  areg_t [DECODE_WIDTH-1:0]     rn_dest_i,
  input  logic [DECODE_WIDTH-1:0]      rn_dest_valid_i,
  input  preg_t [DECODE_WIDTH-1:0]     rn_preg_i,
  input  logic [DECODE_WIDTH-1:0]      rn_ckpt_req_i,
  output preg_t [DECODE_WIDTH-1:0]     rn_psrc0_o,
  output preg_t [DECODE_WIDTH-1:0]     rn_psrc1_o,
  output preg_t [DECODE_WIDTH-1:0]     rn_ppdst_o,
  output ckpt_id_t                     rn_ckpt_id_o,
  input  logic [DECODE_WIDTH-1:0]      cm_valid_i,
  input  areg_t [DECODE_WIDTH-1:0]     cm_dest_i,
  input  preg_t [DECODE_WIDTH-1:0]     cm_preg_i,
  input  logic                         cm_ckpt_free_i,
  input  logic                         redirect_i,
  input  ckpt_id_t                     redirect_ckpt_i,
  input  logic                         flush_i,
  output logic                         ckpt_full_o,
  output logic                         ckpt_empty_o
);

`ifdef RAT_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // With the zero-register feature, r0 is never written anywhere, so its
  // entry stays at the identity value 0 and reads of r0 return 0.
  function automatic logic writable(areg_t r);
    return !(ZERO_REG_EN && (r == '0));
  endfunction

  rat_t spec_map, arch_map;
  rat_t spec_next, arch_next;
  rat_t group_map, snap_map, redirect_map;
  logic ckpt_req_any, fire, alloc;

  assign ckpt_req_any = |(rn_ckpt_req_i & rn_valid_i);
  assign rn_ready_o   = !(ckpt_full_o && ckpt_req_any) && !redirect_i && !flush_i;
  assign fire         = (|rn_valid_i) && rn_ready_o;
  assign alloc        = fire && ckpt_req_any;

  // Lanes are applied in program order to a working copy of the map: each
  // lane reads the copy before writing it, which yields the intra-group
  // bypass for sources and the previous destination, and leaves the last
  // writer of each register in place. The branch lane's snapshot is the
  // working copy right after that lane.
  always_comb begin
    group_map  = spec_map;
    snap_map   = spec_map;
    rn_psrc0_o = '0;
    rn_psrc1_o = '0;
    rn_ppdst_o = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rn_psrc0_o[i] = group_map[rn_src0_i[i]];
      rn_psrc1_o[i] = group_map[rn_src1_i[i]];
      rn_ppdst_o[i] = group_map[rn_dest_i[i]];
      if (rn_valid_i[i] && rn_dest_valid_i[i] && writable(rn_dest_i[i])) begin
        group_map[rn_dest_i[i]] = rn_preg_i[i];
      end
      if (rn_valid_i[i] && rn_ckpt_req_i[i]) begin
        snap_map = group_map;
      end
    end
  end

  // Commit lanes in order, so the highest lane wins on a shared dest.
  always_comb begin
    arch_next = arch_map;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (cm_valid_i[i] && writable(cm_dest_i[i])) begin
        arch_next[cm_dest_i[i]] = cm_preg_i[i];
      end
    end
  end

  // Flush restores from the arch map including this cycle's commits.
  always_comb begin
    spec_next = spec_map;
    if (flush_i) begin
      spec_next = arch_next;
    end else if (redirect_i) begin
      spec_next = redirect_map;
    end else if (fire) begin
      spec_next = group_map;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_map <= RAT_RESET_IDENTITY;
      arch_map <= RAT_RESET_IDENTITY;
    end else begin
      spec_map <= spec_next;
      arch_map <= arch_next;
    end
  end

  rat_ckpt_ring u_ring (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc        (alloc),
    .alloc_map    (snap_map),
    .alloc_id     (rn_ckpt_id_o),
    .free         (cm_ckpt_free_i),
    .redirect     (redirect_i),
    .redirect_id  (redirect_ckpt_i),
    .redirect_map (redirect_map),
    .flush        (flush_i),
    .full         (ckpt_full_o),
    .empty        (ckpt_empty_o)
  );

  a_one_ckpt_req : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rn_ckpt_req_i));

endmodule

// File: tb/tb_rename_map_table.sv
// ---------------------------------------------------------------------------
// tb_rename_map_table
// Self-checking bench for rename_map_table. A reference model holds the
// speculative and architectural maps as plain arrays and the checkpoints as
// a queue of (id, map) entries; expected rename results come from searching
// earlier lanes of the group for the youngest writer.
// ---------------------------------------------------------------------------
module tb_rename_map_table;
  import rat_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic [DECODE_WIDTH-1:0] rn_valid;
  logic                    rn_ready;
  areg_t [DECODE_WIDTH-1:0] rn_src0, rn_src1, rn_dest;
  logic [DECODE_WIDTH-1:0] rn_dest_valid;
  preg_t [DECODE_WIDTH-1:0] rn_preg;
  logic [DECODE_WIDTH-1:0] rn_ckpt_req;
  preg_t [DECODE_WIDTH-1:0] rn_psrc0, rn_psrc1, rn_ppdst;
  ckpt_id_t                rn_ckpt_id;
  logic [DECODE_WIDTH-1:0] cm_valid;
  areg_t [DECODE_WIDTH-1:0] cm_dest;
  preg_t [DECODE_WIDTH-1:0] cm_preg;
  logic                    cm_ckpt_free;
  logic                    redirect;
  ckpt_id_t                redirect_ckpt;
  logic                    flush;
  logic                    ckpt_full, ckpt_empty;

  int checks = 0;
  int fails  = 0;

`ifdef RAT_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  rename_map_table dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rn_valid_i      (rn_valid),
    .rn_ready_o      (rn_ready),
    .rn_src0_i       (rn_src0),
    .rn_src1_i       (rn_src1),
    .rn_dest_i       (rn_dest),
    .rn_dest_valid_i (rn_dest_valid),
    .rn_preg_i       (rn_preg),
    .rn_ckpt_req_i   (rn_ckpt_req),
    .rn_psrc0_o      (rn_psrc0),
    .rn_psrc1_o      (rn_psrc1),
    .rn_ppdst_o      (rn_ppdst),
    .rn_ckpt_id_o    (rn_ckpt_id),
    .cm_valid_i      (cm_valid),
    .cm_dest_i       (cm_dest),
    .cm_preg_i       (cm_preg),
    .cm_ckpt_free_i  (cm_ckpt_free),
    .redirect_i      (redirect),
    .redirect_ckpt_i (redirect_ckpt),
    .flush_i         (flush),
    .ckpt_full_o     (ckpt_full),
    .ckpt_empty_o    (ckpt_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct packed {
    ckpt_id_t id;
    rat_t     map;
  } ckpt_t;

  int    m_spec [ARCH_REG_NUM];
  int    m_arch [ARCH_REG_NUM];
  ckpt_t m_ring [$];
  int    m_tail;

  task automatic modelReset();
    for (int r = 0; r < ARCH_REG_NUM; r++) begin
      m_spec[r] = r;
      m_arch[r] = r;
    end
    m_ring.delete();
    m_tail = 0;
  endtask

  function automatic bit skipReg(int r);
    return ZERO_EN && (r == 0);
  endfunction

  // Youngest earlier lane of the group that writes r, else the spec map.
  function automatic int lookup(int lane, int r);
    if (skipReg(r)) return 0;
    for (int j = lane - 1; j >= 0; j--) begin
      if (rn_valid[j] && rn_dest_valid[j] && int'(rn_dest[j]) == r) return int'(rn_preg[j]);
    end
    return m_spec[r];
  endfunction

  function automatic bit modelReady();
    bit full_now = (m_ring.size() == CKPT_NUM);
    return !(full_now && (|(rn_ckpt_req & rn_valid))) && !redirect && !flush;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("rn_ready", 32'(rn_ready), 32'(modelReady()));
    check("ckpt_full", 32'(ckpt_full), 32'(m_ring.size() == CKPT_NUM));
    check("ckpt_empty", 32'(ckpt_empty), 32'(m_ring.size() == 0));
    check("ckpt_id", 32'(rn_ckpt_id), 32'(m_tail));
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      check($sformatf("psrc0[%0d]", i), 32'(rn_psrc0[i]), 32'(lookup(i, int'(rn_src0[i]))));
      check($sformatf("psrc1[%0d]", i), 32'(rn_psrc1[i]), 32'(lookup(i, int'(rn_src1[i]))));
      check($sformatf("ppdst[%0d]", i), 32'(rn_ppdst[i]), 32'(lookup(i, int'(rn_dest[i]))));
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelEdge();
    int  arch_n [ARCH_REG_NUM];
    int  work [ARCH_REG_NUM];
    rat_t snap;
    bit  fire_now, has_snap;
    int  idx;
    fire_now = (|rn_valid) && modelReady();
    arch_n = m_arch;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (cm_valid[i] && !skipReg(int'(cm_dest[i]))) arch_n[cm_dest[i]] = int'(cm_preg[i]);
    end
    if (flush) begin
      m_spec = arch_n;
      m_ring.delete();
      m_tail = 0;
    end else begin
      if (cm_ckpt_free) void'(m_ring.pop_front());
      if (redirect) begin
        idx = -1;
        foreach (m_ring[k]) if (m_ring[k].id == redirect_ckpt) idx = k;
        if (idx < 0) begin
          check("redirect_target_live", 0, 1);
        end else begin
          for (int r = 0; r < ARCH_REG_NUM; r++) m_spec[r] = int'(m_ring[idx].map[r]);
          while (m_ring.size() > idx + 1) void'(m_ring.pop_back());
          m_tail = (int'(redirect_ckpt) + 1) % CKPT_NUM;
        end
      end else if (fire_now) begin
        work = m_spec;
        has_snap = 1'b0;
        snap = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
          if (rn_valid[i] && rn_dest_valid[i] && !skipReg(int'(rn_dest[i])))
            work[rn_dest[i]] = int'(rn_preg[i]);
          if (rn_valid[i] && rn_ckpt_req[i]) begin
            has_snap = 1'b1;
            for (int r = 0; r < ARCH_REG_NUM; r++) snap[r] = preg_t'(work[r]);
          end
        end
        m_spec = work;
        if (has_snap) begin
          m_ring.push_back('{id: ckpt_id_t'(m_tail), map: snap});
          m_tail = (m_tail + 1) % CKPT_NUM;
        end
      end
    end
    m_arch = arch_n;
  endtask

  task automatic clearInputs();
    rn_valid = '0; rn_src0 = '0; rn_src1 = '0; rn_dest = '0;
    rn_dest_valid = '0; rn_preg = '0; rn_ckpt_req = '0;
    cm_valid = '0; cm_dest = '0; cm_preg = '0; cm_ckpt_free = 1'b0;
    redirect = 1'b0; redirect_ckpt = '0; flush = 1'b0;
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are compared
  // 3 ns later, well before the next edge.
  task automatic settle();
    #3;
    checkOutput();
  endtask

  task automatic clockEdge();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus();
    int n, idx;
    clearInputs();
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      rn_valid[i]      = ($urandom_range(0, 3) != 0);
      rn_src0[i]       = areg_t'($urandom_range(0, 31));
      rn_src1[i]       = areg_t'($urandom_range(0, 31));
      rn_dest[i]       = areg_t'($urandom_range(0, 31));
      rn_dest_valid[i] = ($urandom_range(0, 3) != 0);
      rn_preg[i]       = preg_t'($urandom_range(0, 63));
      cm_valid[i]      = ($urandom_range(0, 2) == 0);
      cm_dest[i]       = areg_t'($urandom_range(0, 31));
      cm_preg[i]       = preg_t'($urandom_range(0, 63));
    end
    if ($urandom_range(0, 1) == 0) rn_ckpt_req[$urandom_range(0, DECODE_WIDTH - 1)] = 1'b1;
    n = m_ring.size();
    if (n > 0 && $urandom_range(0, 3) == 0) cm_ckpt_free = 1'b1;
    if ($urandom_range(0, 7) == 0) begin
      if (cm_ckpt_free && n > 1) begin
        idx = $urandom_range(1, n - 1);
        redirect = 1'b1;
        redirect_ckpt = m_ring[idx].id;
      end else if (!cm_ckpt_free && n > 0) begin
        idx = $urandom_range(0, n - 1);
        redirect = 1'b1;
        redirect_ckpt = m_ring[idx].id;
      end
    end
    if ($urandom_range(0, 29) == 0) flush = 1'b1;
  endtask

  initial begin
    clearInputs();
    modelReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    rn_src0[0] = 5;
    settle();
    check("t1_psrc0_r5", 32'(rn_psrc0[0]), 5);
    check("t1_empty", 32'(ckpt_empty), 1);
    check("t1_full", 32'(ckpt_full), 0);
    clockEdge();

    // In-group RAW / ppdst bypass
    clearInputs();
    rn_valid = 4'b0111;
    rn_dest[0] = 3; rn_dest_valid[0] = 1; rn_preg[0] = 40;
    rn_src0[1] = 3; rn_dest[1] = 3; rn_dest_valid[1] = 1; rn_preg[1] = 41;
    rn_src1[2] = 3;
    settle();
    check("t2_l1_psrc0", 32'(rn_psrc0[1]), 40);
    check("t2_l1_ppdst", 32'(rn_ppdst[1]), 40);
    check("t2_l2_psrc1", 32'(rn_psrc1[2]), 41);
    clockEdge();
    clearInputs();
    rn_src0[0] = 3;
    settle();
    check("t2_r3_after", 32'(rn_psrc0[0]), 41);
    clockEdge();

    // Checkpoint mid-group, then redirect to it
    clearInputs();
    rn_valid = 4'b0111;
    rn_dest[0] = 7; rn_dest_valid[0] = 1; rn_preg[0] = 50;
    rn_ckpt_req[1] = 1;
    rn_dest[2] = 7; rn_dest_valid[2] = 1; rn_preg[2] = 51;
    settle();
    check("t3_ckpt_id", 32'(rn_ckpt_id), 0);
    clockEdge();
    clearInputs();
    redirect = 1; redirect_ckpt = 0;
    rn_valid = 4'b0001;
    settle();
    check("t3_ready_blocked", 32'(rn_ready), 0);
    clockEdge();
    clearInputs();
    rn_src0[0] = 7;
    settle();
    check("t3_r7_restored", 32'(rn_psrc0[0]), 50);
    check("t3_tail", 32'(rn_ckpt_id), 1);
    check("t3_not_empty", 32'(ckpt_empty), 0);
    clockEdge();

    // Fill the ring, stall, free, wrap
    clearInputs();
    flush = 1;
    settle();
    clockEdge();
    for (int k = 0; k < CKPT_NUM; k++) begin
      clearInputs();
      rn_valid[0] = 1; rn_ckpt_req[0] = 1;
      settle();
      check("t4_alloc_id", 32'(rn_ckpt_id), 32'(k));
      clockEdge();
    end
    clearInputs();
    rn_valid[0] = 1; rn_ckpt_req[0] = 1;
    settle();
    check("t4_full", 32'(ckpt_full), 1);
    check("t4_ready_low", 32'(rn_ready), 0);
    cm_ckpt_free = 1;
    settle();
    check("t4_ready_low_free", 32'(rn_ready), 0);
    clockEdge();
    cm_ckpt_free = 0;
    settle();
    check("t4_ready_high", 32'(rn_ready), 1);
    check("t4_id_wrap", 32'(rn_ckpt_id), 0);
    clockEdge();

    // Commit then flush restores the committed mapping
    clearInputs();
    flush = 1;
    settle();
    clockEdge();
    clearInputs();
    cm_valid[0] = 1; cm_dest[0] = 9; cm_preg[0] = 60;
    rn_valid[0] = 1; rn_dest[0] = 9; rn_dest_valid[0] = 1; rn_preg[0] = 61;
    settle();
    clockEdge();
    clearInputs();
    rn_src0[0] = 9;
    settle();
    check("t5_r9_spec", 32'(rn_psrc0[0]), 61);
    flush = 1;
    settle();
    clockEdge();
    clearInputs();
    rn_src0[0] = 9;
    settle();
    check("t5_r9_flushed", 32'(rn_psrc0[0]), 60);
    check("t5_empty", 32'(ckpt_empty), 1);
    clockEdge();

    // Destination r0
    clearInputs();
    rn_valid[0] = 1; rn_dest[0] = 0; rn_dest_valid[0] = 1; rn_preg[0] = 33;
    settle();
    check("t6_ppdst_r0", 32'(rn_ppdst[0]), 0);
    clockEdge();
    clearInputs();
    settle();
    check("t6_r0_read", 32'(rn_psrc0[0]), ZERO_EN ? 0 : 33);
    clockEdge();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      settle();
      clockEdge();
    end

    // Asynchronous reset in the middle of a cycle
    applyStimulus();
    redirect = 0; flush = 0; cm_ckpt_free = 0;
    #2;
    rst_n = 1'b0;
    modelReset();
    clearInputs();
    for (int i = 0; i < DECODE_WIDTH; i++) rn_src0[i] = areg_t'(i + 10);
    #1;
    checkOutput();
    check("rst_psrc0_l1", 32'(rn_psrc0[1]), 11);
    check("rst_empty", 32'(ckpt_empty), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      applyStimulus();
      settle();
      clockEdge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
